// File: rtl/timer_cmp.sv
// Compare/interrupt unit fed by the free-running timer counter: one-shot or periodic compare with level irq.
// Optional TIMER_CMP_MISS_COUNT_EN adds a saturating MISS counter at offset 0x10.
module timer_cmp (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] counter,
  input  logic        bus_r_en,
  input  logic [31:0] bus_r_addr,
  output logic [31:0] bus_r_data,
  input  logic        bus_w_en,
  input  logic [31:0] bus_w_addr,
  input  logic [31:0] bus_w_data,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_CMP    = 32'h00;
  localparam logic [31:0] ADDR_CTRL   = 32'h04;
  localparam logic [31:0] ADDR_STATUS = 32'h08;
  localparam logic [31:0] ADDR_PERIOD = 32'h0C;
  localparam logic [31:0] ADDR_MISS   = 32'h10;

  state_t      state, state_next;
  logic [31:0] cmp, period;
  logic        en, periodic, ie, pending;
  logic        w_cmp, w_ctrl, w_status, w_period, clear;
  logic        behind, hit, reload;

  // Bus has no handshake: a write with bus_w_en high is taken at the next edge, reads are combinational.
  assign w_cmp    = bus_w_en && (bus_w_addr == ADDR_CMP);
  assign w_ctrl   = bus_w_en && (bus_w_addr == ADDR_CTRL);
  assign w_status = bus_w_en && (bus_w_addr == ADDR_STATUS);
  assign w_period = bus_w_en && (bus_w_addr == ADDR_PERIOD);
  assign clear    = w_status && bus_w_data[0];

  // Wrap-safe compare: counter at or past cmp within half the range.
  assign behind = (counter - cmp) >= 32'h8000_0000;
  assign hit    = (state == ARMED) && !behind;
  assign reload = hit && periodic && (period != 32'd0);

  always_comb begin
    state_next = state;
    case (state)
      ARMED:   if (hit && !reload) state_next = DONE;
      DONE:    if (w_cmp && en) state_next = ARMED;
      default: state_next = state;
    endcase
    if (w_ctrl) state_next = bus_w_data[0] ? ARMED : IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cmp      <= 32'd0;
      period   <= 32'd0;
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      pending  <= 1'b0;
    end else begin
      state <= state_next;
      if (w_cmp) cmp <= bus_w_data;
      else if (reload) cmp <= cmp + period;
      if (w_period) period <= bus_w_data;
      if (w_ctrl) begin
        en       <= bus_w_data[0];
        periodic <= bus_w_data[1];
        ie       <= bus_w_data[2];
      end
      if (hit) pending <= 1'b1;
      else if (clear) pending <= 1'b0;
    end
  end

`ifdef TIMER_CMP_MISS_COUNT_EN
  logic [7:0] miss;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) miss <= 8'd0;
    else if (clear) miss <= 8'd0;
    else if (hit && pending && (miss != 8'hFF)) miss <= miss + 8'd1;
  end
`endif

  always_comb begin
    bus_r_data = 32'd0;
    if (bus_r_en) begin
      case (bus_r_addr)
        ADDR_CMP:    bus_r_data = cmp;
        ADDR_CTRL:   bus_r_data = {29'd0, ie, periodic, en};
        ADDR_STATUS: bus_r_data = {29'd0, state, pending};
        ADDR_PERIOD: bus_r_data = period;
`ifdef TIMER_CMP_MISS_COUNT_EN
        ADDR_MISS:   bus_r_data = {24'd0, miss};
`endif
        default:     bus_r_data = 32'd0;
      endcase
    end
  end

  assign irq = pending & ie;

endmodule

// File: tb/tb_timer_cmp.sv
// Directed bench for timer_cmp: vector table for one-shot/periodic/wrap flows, hand sequences for catch-up and reset.
module tb_timer_cmp;

  localparam logic [31:0] A_CMP  = 32'h00;
  localparam logic [31:0] A_CTRL = 32'h04;
  localparam logic [31:0] A_STAT = 32'h08;
  localparam logic [31:0] A_PER  = 32'h0C;
  localparam logic [31:0] A_MISS = 32'h10;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] counter;
  logic        bus_r_en;
  logic [31:0] bus_r_addr;
  logic [31:0] bus_r_data;
  logic        bus_w_en;
  logic [31:0] bus_w_addr;
  logic [31:0] bus_w_data;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] cnt;
    logic [31:0] ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[35];

  timer_cmp dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .counter    (counter),
    .bus_r_en   (bus_r_en),
    .bus_r_addr (bus_r_addr),
    .bus_r_data (bus_r_data),
    .bus_w_en   (bus_w_en),
    .bus_w_addr (bus_w_addr),
    .bus_w_data (bus_w_data),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                             input logic [31:0] cnt, input logic [31:0] ra,
                             input logic [31:0] exp_rd, input logic exp_irq);
    vec_t r;
    r.we = we; r.wa = wa; r.wd = wd; r.cnt = cnt;
    r.ra = ra; r.exp_rd = exp_rd; r.exp_irq = exp_irq;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: inputs driven at negedge, applied at posedge, write strobe dropped just after.
  task automatic do_cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                          input logic [31:0] cnt);
    @(negedge clk);
    bus_w_en   = we;
    bus_w_addr = wa;
    bus_w_data = wd;
    counter    = cnt;
    @(posedge clk);
    #1;
    bus_w_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_r_en   = 1'b1;
    bus_r_addr = addr;
    #1;
    check(name, bus_r_data, exp);
    bus_r_en   = 1'b0;
    bus_r_addr = 32'd0;
  endtask

  initial begin
    // one-shot
    vecs[0]  = v(1, A_CMP,  32'h10, 32'h00, A_CMP,  32'h10, 0);
    vecs[1]  = v(1, A_CTRL, 32'h05, 32'h00, A_CTRL, 32'h05, 0);
    vecs[2]  = v(0, 0, 0, 32'h0E, A_STAT, 32'h2, 0);
    vecs[3]  = v(0, 0, 0, 32'h0F, A_STAT, 32'h2, 0);
    vecs[4]  = v(0, 0, 0, 32'h10, A_STAT, 32'h5, 1);
    vecs[5]  = v(1, A_STAT, 32'h1, 32'h11, A_STAT, 32'h4, 0);
    vecs[6]  = v(0, 0, 0, 32'h12, A_STAT, 32'h4, 0);
    // periodic
    vecs[7]  = v(1, A_PER,  32'h08, 32'h12, A_PER,  32'h08, 0);
    vecs[8]  = v(1, A_CMP,  32'h10, 32'h00, A_STAT, 32'h2, 0);
    vecs[9]  = v(1, A_CTRL, 32'h07, 32'h0F, A_CTRL, 32'h07, 0);
    vecs[10] = v(0, 0, 0, 32'h10, A_CMP, 32'h18, 1);
    vecs[11] = v(1, A_STAT, 32'h1, 32'h11, A_STAT, 32'h2, 0);
    vecs[12] = v(0, 0, 0, 32'h18, A_STAT, 32'h3, 1);
    vecs[13] = v(1, A_STAT, 32'h1, 32'h19, A_STAT, 32'h2, 0);
    vecs[14] = v(0, 0, 0, 32'h20, A_CMP, 32'h28, 1);
    vecs[15] = v(1, A_STAT, 32'h1, 32'h21, A_CMP, 32'h28, 0);
    // hit with clear, hit with CMP write, hit with CTRL write
    vecs[16] = v(1, A_STAT, 32'h1,   32'h28,  A_STAT, 32'h3,   1);
    vecs[17] = v(1, A_CMP,  32'h100, 32'h30,  A_CMP,  32'h100, 1);
    vecs[18] = v(1, A_STAT, 32'h1,   32'h31,  A_STAT, 32'h2,   0);
    vecs[19] = v(1, A_CTRL, 32'h4,   32'h100, A_STAT, 32'h1,   1);
    vecs[20] = v(1, A_STAT, 32'h1,   32'h200, A_STAT, 32'h0,   0);
    // unmapped read/write
    vecs[21] = v(0, 0, 0, 32'h0, A_MISS, 32'h0, 0);
    vecs[22] = v(1, 32'h14, 32'hFFFF_FFFF, 32'h0, A_CTRL, 32'h4, 0);
    // wrap around zero
    vecs[23] = v(1, A_CMP,  32'h4, 32'hFFFF_FFF0, A_CMP,  32'h4, 0);
    vecs[24] = v(1, A_CTRL, 32'h5, 32'hFFFF_FFF0, A_STAT, 32'h2, 0);
    vecs[25] = v(0, 0, 0, 32'hFFFF_FFF8, A_STAT, 32'h2, 0);
    vecs[26] = v(0, 0, 0, 32'hFFFF_FFFF, A_STAT, 32'h2, 0);
    vecs[27] = v(0, 0, 0, 32'h0,         A_STAT, 32'h2, 0);
    vecs[28] = v(0, 0, 0, 32'h3,         A_STAT, 32'h2, 0);
    vecs[29] = v(0, 0, 0, 32'h4,         A_STAT, 32'h5, 1);
    vecs[30] = v(1, A_STAT, 32'h1, 32'h5, A_STAT, 32'h4, 0);
    // half-range boundary with CMP=0xFFFFFFFF
    vecs[31] = v(1, A_CMP, 32'hFFFF_FFFF, 32'h1000_0000, A_CMP, 32'hFFFF_FFFF, 0);
    vecs[32] = v(0, 0, 0, 32'h8000_0000, A_STAT, 32'h2, 0);
    vecs[33] = v(0, 0, 0, 32'h7FFF_FFFF, A_STAT, 32'h2, 0);
    vecs[34] = v(0, 0, 0, 32'h7FFF_FFFE, A_STAT, 32'h5, 1);

    n_rst      = 1'b0;
    counter    = 32'd0;
    bus_r_en   = 1'b0;
    bus_r_addr = 32'd0;
    bus_w_en   = 1'b0;
    bus_w_addr = 32'd0;
    bus_w_data = 32'd0;

    #2;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rdata_idle", bus_r_data, 32'd0);
    read_check("reset_cmp", A_CMP, 32'd0);
    read_check("reset_ctrl", A_CTRL, 32'd0);
    read_check("reset_status", A_STAT, 32'd0);
    read_check("reset_period", A_PER, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 35; i++) begin
      do_cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cnt);
      read_check($sformatf("vec%0d_rdata", i), vecs[i].ra, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    bus_r_en   = 1'b0;
    bus_r_addr = A_CTRL;
    #1;
    check("rdata_when_r_en_low", bus_r_data, 32'd0);

    // Periodic catch-up: counter far ahead, PERIOD=1, pending never cleared.
    do_cycle(1, A_CTRL, 32'h0, 32'd0);
    do_cycle(1, A_CMP,  32'h0, 32'd0);
    do_cycle(1, A_PER,  32'h1, 32'd0);
    do_cycle(1, A_CTRL, 32'h7, 32'd1000);
    repeat (300) do_cycle(0, 0, 0, 32'd1000);
    read_check("catchup_cmp", A_CMP, 32'd300);
    read_check("catchup_status", A_STAT, 32'h3);
    check("catchup_irq", {31'd0, irq}, 32'd1);
`ifdef TIMER_CMP_MISS_COUNT_EN
    read_check("miss_saturated", A_MISS, 32'hFF);
`else
    read_check("miss_unmapped", A_MISS, 32'h0);
`endif
    do_cycle(0, 0, 0, 32'd0);
    do_cycle(1, A_STAT, 32'h1, 32'd0);
    read_check("clear_nohit_status", A_STAT, 32'h2);
    check("clear_nohit_irq", {31'd0, irq}, 32'd0);
    read_check("clear_nohit_miss", A_MISS, 32'h0);
    do_cycle(0, 0, 0, 32'h12C);
    do_cycle(1, A_STAT, 32'h1, 32'h12D);
    read_check("hit_clear_status", A_STAT, 32'h3);
    read_check("hit_clear_miss", A_MISS, 32'h0);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);

    // Asynchronous reset between edges.
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    read_check("async_reset_cmp", A_CMP, 32'd0);
    read_check("async_reset_status", A_STAT, 32'd0);
    read_check("async_reset_ctrl", A_CTRL, 32'd0);
    read_check("async_reset_period", A_PER, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
